// File: rtl/memory_pkg.sv
// Shared definitions for the burst memory block.
//   mem_state_t : transfer controller states
//   BUS_Z       : one bit of an undriven bus, replicated to the bus width by users
//   wrap_inc    : pointer increment that wraps modulo 2^m
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam logic BUS_Z = 1'bz;

  // Widest pointer wrap_inc handles; callers cast in and out of this width.
  localparam int PTR_W = 16;

  // Next address of a burst: ptr+1, wrapping from 2^m-1 back to 0.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr,
                                                input int unsigned m);
    logic [PTR_W-1:0] mask;
    mask = PTR_W'((32'd1 << m) - 32'd1);
    return (ptr + PTR_W'(1)) & mask;
  endfunction

endpackage

// File: rtl/memory_array.sv
// Storage for the burst memory: 2^M words of N bits.
//   Clock  : system clock, rising edge
//   ResetN : asynchronous active-low clear of every word
//   we     : write enable, word waddr takes wdata at the rising edge
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : combinational read data of word raddr
module memory_array #(
  parameter int N = 8,
  parameter int M = 2
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         we,
  input  logic [M-1:0] waddr,
  input  logic [N-1:0] wdata,
  input  logic [M-1:0] raddr,
  output logic [N-1:0] rdata
);

  localparam int DEPTH = 1 << M;

  logic [N-1:0] bank [DEPTH];

  // One register per word so the whole array clears in the reset itself.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [N-1:0] word_reg;

      always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
          word_reg <= '0;
        end else if (we && (waddr == M'(gi))) begin
          word_reg <= wdata;
        end
      end

      assign bank[gi] = word_reg;
    end
  endgenerate

  assign rdata = bank[raddr];

endmodule

// File: rtl/burst_memory.sv
// Burst memory on the shared system bus, driven by the control unit.
// A request taken in IDLE starts a burst of Len+1 beats from Addr; the
// address auto-increments and wraps at the top of the array. Reads wait
// READ_LATENCY cycles before the first beat; writes start immediately.
//   Clock  : system clock, rising edge
//   ResetN : asynchronous active-low reset, aborts any burst
//   Req    : transfer request, looked at only in IDLE
//   RW     : 1 = write (master drives Bus), 0 = read (memory drives Bus)
//   Addr   : burst start address
//   Len    : burst length minus one
//   Bus    : shared bidirectional data bus
//   Ready  : current cycle is a data beat
//   Done   : one-cycle pulse after the last beat
//   Busy   : a transfer is in progress (state is not IDLE)
module burst_memory
  import memory_pkg::*;
#(
  parameter int N            = 8,
  parameter int M            = 2,
  parameter int L            = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         Req,
  input  logic         RW,
  input  logic [M-1:0] Addr,
  input  logic [L-1:0] Len,
  inout  wire  [N-1:0] Bus,
  output logic         Ready,
  output logic         Done,
  output logic         Busy
);

  // Countdown start for WAIT; unused when the latency is zero because the
  // read then goes straight to XFER.
  localparam logic [1:0] LAT_INIT = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

  mem_state_t   state_reg;
  logic [M-1:0] ptr_reg;
  logic [L-1:0] cnt_reg;
  logic         dir_reg;
  logic [1:0]   lat_reg;

  logic [N-1:0] rdata;
  logic         we;
  logic         drive;

  assign we    = (state_reg == XFER) &&  dir_reg;
  assign drive = (state_reg == XFER) && !dir_reg;

  // Memory drives the bus only on read beats; reset forces IDLE, so it
  // also releases the bus the moment ResetN falls.
  assign Bus = drive ? rdata : {N{BUS_Z}};

  memory_array #(
    .N(N),
    .M(M)
  ) u_array (
    .Clock (Clock),
    .ResetN(ResetN),
    .we    (we),
    .waddr (ptr_reg),
    .wdata (Bus),
    .raddr (ptr_reg),
    .rdata (rdata)
  );

  // Ready/Done/Busy are registered alongside the state so they change
  // exactly when the state does.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
      lat_reg   <= 2'd0;
      Ready     <= 1'b0;
      Done      <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Req) begin
            ptr_reg <= Addr;
            cnt_reg <= Len;
            dir_reg <= RW;
            lat_reg <= LAT_INIT;
            Busy    <= 1'b1;
            if (RW || (READ_LATENCY == 0)) begin
              state_reg <= XFER;
              Ready     <= 1'b1;
            end else begin
              state_reg <= WAIT;
            end
          end
        end

        WAIT: begin
          lat_reg <= lat_reg - 2'd1;
          if (lat_reg == 2'd0) begin
            state_reg <= XFER;
            Ready     <= 1'b1;
          end
        end

        XFER: begin
          ptr_reg <= M'(wrap_inc(PTR_W'(ptr_reg), M));
          if (cnt_reg == '0) begin
            state_reg <= DONE;
            Ready     <= 1'b0;
            Done      <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - L'(1);
          end
        end

        DONE: begin
          state_reg <= IDLE;
          Done      <= 1'b0;
          Busy      <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          Ready     <= 1'b0;
          Done      <= 1'b0;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_memory.sv
// Bench for burst_memory: three instances with read latencies 1, 0 and 3,
// each with its own stimulus, timeline model and per-cycle compare.
module tb_burst_memory;

  localparam int N    = 8;
  localparam int M    = 2;
  localparam int L    = 2;
  localparam int D    = 1 << M;
  localparam int MAXC = 4096;
  localparam int NI   = 3;

  logic Clock;
  int   checks = 0;
  int   errors = 0;
  bit   fin [NI];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input int inst, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %0h expected %0h at %0t", inst, name, act, exp, $time);
    end
  endtask

  function automatic int rl_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_inst
      localparam int RL = rl_of(gi);

      logic         ResetN;
      logic         Req;
      logic         RW;
      logic [M-1:0] Addr;
      logic [L-1:0] Len;
      wire  [N-1:0] Bus;
      logic         Ready;
      logic         Done;
      logic         Busy;

      logic         drv_en;
      logic [N-1:0] drv_data;

      assign Bus = drv_en ? drv_data : 'z;

      burst_memory #(
        .N(N), .M(M), .L(L), .READ_LATENCY(RL)
      ) dut (
        .Clock (Clock),
        .ResetN(ResetN),
        .Req   (Req),
        .RW    (RW),
        .Addr  (Addr),
        .Len   (Len),
        .Bus   (Bus),
        .Ready (Ready),
        .Done  (Done),
        .Busy  (Busy)
      );

      // Model: memory contents plus a timeline of what each cycle must show.
      // Cycle k is the interval that begins at clock edge k.
      logic [N-1:0] mem_m [D];
      bit           e_ready [MAXC];
      bit           e_done  [MAXC];
      bit           e_busy  [MAXC];
      bit           e_rd    [MAXC];
      bit           e_wr    [MAXC];
      logic [N-1:0] e_data  [MAXC];
      logic [M-1:0] e_addr  [MAXC];
      int           cyc = 0;

      logic [N-1:0] wq [$];   // data the master drives on upcoming write beats
      logic [N-1:0] rq [$];   // read beats observed on the bus
      logic [N-1:0] ev [$];   // expected read sequence for chk_seq

      // A burst accepted at edge c: wait cycles, beats, then one Done cycle.
      task automatic schedule(input int c, input bit rw, input int a, input int ln);
        int eff;
        eff = rw ? 0 : RL;
        for (int i = 0; i <= eff + ln + 1; i++) e_busy[(c + i) % MAXC] = 1'b1;
        for (int j = 0; j <= ln; j++) begin
          int s;
          s = (c + eff + j) % MAXC;
          e_ready[s] = 1'b1;
          e_addr[s]  = M'((a + j) % D);
          if (rw) e_wr[s] = 1'b1;
          else begin
            e_rd[s]   = 1'b1;
            e_data[s] = mem_m[(a + j) % D];
          end
        end
        e_done[(c + eff + ln + 1) % MAXC] = 1'b1;
      endtask

      task automatic clear_all();
        for (int i = 0; i < MAXC; i++) begin
          e_ready[i] = 1'b0; e_done[i] = 1'b0; e_busy[i] = 1'b0;
          e_rd[i] = 1'b0; e_wr[i] = 1'b0;
        end
        for (int i = 0; i < D; i++) mem_m[i] = '0;
      endtask

      always @(posedge Clock) begin
        int k;
        if (ResetN) begin
          k = cyc % MAXC;
          if (e_wr[k]) mem_m[e_addr[k]] = drv_data;
          if (!e_busy[k] && Req) schedule(cyc + 1, RW, int'(Addr), int'(Len));
          e_ready[k] = 1'b0; e_done[k] = 1'b0; e_busy[k] = 1'b0;
          e_rd[k] = 1'b0; e_wr[k] = 1'b0;
          cyc = cyc + 1;
        end
      end

      always @(negedge ResetN) begin
        clear_all();
        wq.delete();
      end

      // Master drives write data for each write beat, shortly after the edge.
      always @(posedge Clock) begin
        #1;
        if (e_wr[cyc % MAXC]) begin
          drv_en   = 1'b1;
          drv_data = (wq.size() > 0) ? wq.pop_front() : N'($urandom);
        end else begin
          drv_en = 1'b0;
        end
      end

      always @(negedge Clock) begin
        int k;
        k = cyc % MAXC;
        chk(gi, "ready", 32'(Ready), 32'(e_ready[k]));
        chk(gi, "done",  32'(Done),  32'(e_done[k]));
        chk(gi, "busy",  32'(Busy),  32'(e_busy[k]));
        if (e_rd[k]) begin
          chk(gi, "rdata", 32'(Bus), 32'(e_data[k]));
          rq.push_back(Bus);
        end else if (!e_wr[k]) begin
          chk(gi, "bus_released", $isunknown(Bus) ? 32'd0 : 32'(Bus), 32'd0);
        end
      end

      task automatic chk_seq(input string nm);
        chk(gi, {nm, "_len"}, 32'(rq.size()), 32'(ev.size()));
        for (int i = 0; i < ev.size(); i++)
          chk(gi, nm, (i < rq.size()) ? 32'(rq[i]) : 32'hDEAD, 32'(ev[i]));
      endtask

      // One transfer, started at a negedge. abort_at>0 asserts reset during
      // that beat number instead of letting the burst finish.
      task automatic xfer(input bit rw, input int a, input int ln, input int abort_at,
                          output int first, output int beats);
        int guard;
        guard = 0;
        while (e_busy[cyc % MAXC] && guard < 100) begin
          @(negedge Clock);
          guard++;
        end
        Req = 1'b1; RW = rw; Addr = M'(a); Len = L'(ln);
        @(negedge Clock);
        Req = 1'b0; first = -1; beats = 0; guard = 0;
        while (guard < 40) begin
          RW = 1'($urandom); Addr = M'($urandom); Len = L'($urandom);
          if (!e_busy[cyc % MAXC]) break;
          if (Ready) begin
            if (first < 0) first = guard;
            beats++;
          end
          if (abort_at > 0 && beats == abort_at) begin
            #1 ResetN = 1'b0;
            #1;
            chk(gi, "rst_ready", 32'(Ready), 32'd0);
            chk(gi, "rst_busy",  32'(Busy),  32'd0);
            chk(gi, "rst_done",  32'(Done),  32'd0);
            chk(gi, "rst_bus", $isunknown(Bus) ? 32'd0 : 32'(Bus), 32'd0);
            repeat (2) @(negedge Clock);
            ResetN = 1'b1;
            break;
          end
          guard++;
          @(negedge Clock);
        end
        if (guard >= 40) chk(gi, "xfer_timeout", 32'(guard), 32'd0);
        $display("inst%0d RL=%0d %s addr=%0d len=%0d first_ready=%0d beats=%0d%s",
                 gi, RL, rw ? "WR" : "RD", a, ln, first, beats,
                 (abort_at > 0) ? " reset" : "");
      endtask

      initial begin
        int f, b, guard;
        ResetN = 1'b0; Req = 1'b0; RW = 1'b0; Addr = '0; Len = '0;
        drv_en = 1'b0; drv_data = '0;
        clear_all();
        repeat (3) @(negedge Clock);
        ResetN = 1'b1;
        chk(gi, "init_busy", 32'(Busy), 32'd0);

        // Cleared memory reads back as zeros.
        rq.delete();
        xfer(1'b0, 0, 3, 0, f, b);
        ev = {8'h00, 8'h00, 8'h00, 8'h00};
        chk_seq("reset_read");
        chk(gi, "rd_latency", 32'(f), 32'(RL));
        chk(gi, "rd_beats", 32'(b), 32'd4);

        // Single write then single read.
        wq = {8'hA5};
        xfer(1'b1, 2, 0, 0, f, b);
        chk(gi, "wr_first", 32'(f), 32'd0);
        chk(gi, "wr_beats", 32'(b), 32'd1);
        rq.delete();
        xfer(1'b0, 2, 0, 0, f, b);
        ev = {8'hA5};
        chk_seq("single_read");
        chk(gi, "rd1_latency", 32'(f), 32'(RL));

        // Burst crossing the top address.
        wq = {8'h11, 8'h22, 8'h33, 8'h44};
        xfer(1'b1, 3, 3, 0, f, b);
        rq.delete();
        xfer(1'b0, 3, 3, 0, f, b);
        ev = {8'h11, 8'h22, 8'h33, 8'h44};
        chk_seq("wrap_read");
        rq.delete();
        xfer(1'b0, 0, 1, 0, f, b);
        ev = {8'h22, 8'h33};
        chk_seq("wrap_word0");

        // Random transfers with random write data.
        for (int t = 0; t < 60; t++)
          xfer(1'($urandom), int'($urandom_range(D - 1)), int'($urandom_range(3)), 0, f, b);

        // Req held high: the model accepts only in idle cycles.
        Req = 1'b1;
        for (int t = 0; t < 40; t++) begin
          RW = 1'($urandom); Addr = M'($urandom); Len = L'($urandom);
          @(negedge Clock);
        end
        Req = 1'b0;
        guard = 0;
        while (e_busy[cyc % MAXC] && guard < 40) begin
          @(negedge Clock);
          guard++;
        end
        chk(gi, "hold_drain", 32'(e_busy[cyc % MAXC]), 32'd0);

        // Reset during beat 2 of a 4-beat read, then memory must be clear.
        wq = {8'h5A, 8'h6B, 8'h7C, 8'h8D};
        xfer(1'b1, 0, 3, 0, f, b);
        xfer(1'b0, 0, 3, 2, f, b);
        chk(gi, "abort_beats", 32'(b), 32'd2);
        @(negedge Clock);
        rq.delete();
        xfer(1'b0, 0, 3, 0, f, b);
        ev = {8'h00, 8'h00, 8'h00, 8'h00};
        chk_seq("after_reset");

        fin[gi] = 1'b1;
      end
    end
  endgenerate

  initial begin
    int cycles;
    bit all_done;
    cycles = 0;
    all_done = 1'b0;
    while (!all_done && cycles < 20000) begin
      @(posedge Clock);
      cycles++;
      all_done = fin[0] && fin[1] && fin[2];
    end
    if (!all_done) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: got %0d cycles without completion", cycles);
    end
    repeat (2) @(posedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_memory.md
Name: burst_memory

Overview:
Parametrised successor to the single-word bus memory. It holds 2^M words of N bits and shares one bidirectional data bus. It adds a request/ready handshake, configurable read latency, and multi-beat bursts with an auto-incrementing, wrapping address. It sits on the shared system Bus beside the register file and ALU, and is driven by the control unit.

Parameters:
N, 8, data word width in bits
M, 2, address width; depth = 2^M words
L, 2, burst-length field width; max burst = 2^L beats
READ_LATENCY, 1, idle cycles between read acceptance and first read beat (0..3)

Ports:
Clock  in  1  system clock, rising-edge active
ResetN  in  1  reset, asynchronous, active-low
Req  in  1  transfer request, sampled only in IDLE
RW  in  1  1 = write (master drives Bus), 0 = read (memory drives Bus); sampled with Req
Addr  in  M  start address, sampled with Req
Len  in  L  beats minus one, sampled with Req
Bus  inout  N  shared data bus
Ready  out  1  current cycle is a data beat
Done  out  1  one-cycle pulse after the last beat
Busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset, asynchronous, while ResetN=0:
  - state=IDLE; Ready=0, Done=0, Busy=0.
  - Bus is high-Z.
  - All words are cleared to 0.
  - Internal ptr, cnt and dir are cleared to 0.
- Reset asserted mid-burst aborts the burst immediately. No partial Done pulse is produced.
- Latched registers: ptr (M bits), cnt (L bits), dir (1 bit), lat (2 bits).
- FSM states: IDLE, WAIT, XFER, DONE.
- IDLE:
  - At a rising edge with Req=1: ptr<=Addr, cnt<=Len, dir<=RW, lat<=READ_LATENCY-1.
  - Next state is XFER if RW=1 or READ_LATENCY=0; otherwise WAIT.
  - Req=0 keeps the FSM in IDLE.
- WAIT:
  - lat decrements each edge.
  - Leaves to XFER on the edge where lat=0.
  - Exactly READ_LATENCY cycles are spent before the first beat.
- XFER:
  - Ready=1 for the whole state.
  - Write: at each edge mem[ptr]<=Bus. The master must hold valid data on Bus throughout every Ready cycle.
  - Read: Bus=mem[ptr] combinationally throughout the cycle. Data is valid before the edge that ends the beat.
  - Each edge: ptr<=ptr+1 mod 2^M (wraps from 2^M-1 to 0).
  - If cnt=0 go to DONE; else cnt<=cnt-1.
  - Number of beats = Len+1.
- DONE:
  - Done=1, Ready=0, Bus high-Z.
  - Unconditional return to IDLE on the next edge.
  - Req is ignored in DONE. A back-to-back request is accepted in the following IDLE cycle.
- Bus driver: drives only when state=XFER and dir=0; high-Z in every other case, including reset.
- Req, Addr, RW and Len are don't-care outside IDLE. Changes to them mid-burst have no effect.
- Timing, with the request accepted at edge E0:
  - Write: beats sample Bus at edges E1..E(Len+1); Done is high between E(Len+1) and E(Len+2).
  - Read: Ready is high between E(RL) and E(RL+Len+1), where RL=READ_LATENCY; Done is high in the following cycle.
- Burst wrap: a burst may cross the top address; it wraps, with no error and no truncation.
- Read-during-write collision cannot occur: the block is single-ported and handles one transfer at a time.

Decomposition:
- Shared package memory_pkg:
  - state enum mem_state_t {IDLE, WAIT, XFER, DONE}
  - constant BUS_Z
  - function wrap_inc(ptr)
- Sub-module memory_array:
  - Parameters N and M.
  - Inputs: Clock, ResetN, we, waddr, wdata, raddr; output rdata.
  - Synchronous write, combinational read, asynchronous clear.
- burst_memory contains the FSM, counters and tri-state driver only.

Test Plan:
- Reset then idle: ResetN pulse low → Bus=Z, Ready/Done/Busy=0; a read of Len=3 from Addr=0 returns 0,0,0,0.
- Single write/read (N=8, M=2, RL=1):
  - Write Addr=2, Len=0, Bus=0xA5 → Ready for exactly 1 cycle, then Done pulse, mem[2]=0xA5.
  - Read Addr=2 → 1 WAIT cycle, then Bus=0xA5 with Ready=1 for 1 cycle; Bus=Z afterwards.
- Wrapping burst: write Addr=3, Len=3, data 0x11,0x22,0x33,0x44 → mem[3]=0x11, mem[0]=0x22, mem[1]=0x33, mem[2]=0x44; a read burst from Addr=3 returns the same sequence.
- Latency sweep: READ_LATENCY=0 and 3 → first Ready appears 0 and 3 cycles after acceptance; Busy is high from acceptance through Done.
- Protocol robustness:
  - Req held high continuously → new transfers are accepted only in IDLE, with one non-Ready DONE cycle between bursts.
  - Addr/Len toggled mid-burst → no effect on the burst.
- Reset mid-burst: assert ResetN=0 during beat 2 of a 4-beat read → Bus goes Z immediately, FSM=IDLE, no Done pulse, memory reads back as 0.
